// File: rtl/pkg_sha3.sv
// Shared SHA3 constants and types for the message padder and its lane generator.
// The rate geometry defaults to SHA3-256: 17 lanes of 64 bits per absorb block.
package pkg_sha3;

    localparam int SHA3_RATE_LINES = 17;
    localparam int SHA3_LINE_W     = $clog2(SHA3_RATE_LINES);

    localparam logic [7:0] SHA3_DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] SHA3_DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] SHA3_PAD_FINAL    = 8'h80;

    typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FILL} ssPad_t;

    // Selects which kind of lane the generator builds.
    typedef enum logic [1:0] {LANE_DATA, LANE_PAD, LANE_FILL} lane_mode_t;

    // Keeps bytes [nbytes-1:0] of a lane and clears the rest.
    function automatic logic [63:0] byte_keep_mask(input logic [3:0] nbytes);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/sha3_pad_lane_gen.sv
// Combinational builder of one padded lane from a message word, byte count, block line and mode.
// msg_end marks the lane that closes the final block; full_tail marks a last word with no room for padding.
module sha3_pad_lane_gen
    import pkg_sha3::*;
#(
    parameter int         RATE_LINES  = SHA3_RATE_LINES,
    parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN_SHA3,
    localparam int        LINE_W      = $clog2(RATE_LINES)
) (
    input  logic [63:0]       data,
    input  logic [3:0]        nbytes,
    input  logic              last,
    input  logic [LINE_W-1:0] line,
    input  logic [1:0]        mode,
    output logic [63:0]       lane,
    output logic              full_tail,
    output logic              msg_end
);

    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(RATE_LINES - 1);

    lane_mode_t  mode_e;
    logic [3:0]  nb_eff;
    logic        end_line;

    assign mode_e   = lane_mode_t'(mode);
    assign nb_eff   = (nbytes > 4'd8) ? 4'd8 : nbytes;
    assign end_line = (line == LINE_MAX);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        lane      = '0;
        full_tail = 1'b0;
        msg_end   = 1'b0;
        unique case (mode_e)
            LANE_DATA: begin
                if (!last) begin
                    lane = data;
                end else begin
                    lane = data & byte_keep_mask(nb_eff);
                    if (nb_eff == 4'd8) begin
                        full_tail = 1'b1;
                    end else begin
                        lane[{nb_eff[2:0], 3'b000} +: 8] = lane[{nb_eff[2:0], 3'b000} +: 8] | DOMAIN_BYTE;
                        if (end_line) begin
                            lane[63:56] = lane[63:56] | SHA3_PAD_FINAL;
                            msg_end     = 1'b1;
                        end
                    end
                end
            end
            LANE_PAD: begin
                // A whole-word tail ending on the second-to-last line puts both pad bits in this lane.
                lane = {56'h0, DOMAIN_BYTE};
                if (end_line) begin
                    lane[63:56] = SHA3_PAD_FINAL;
                    msg_end     = 1'b1;
                end
            end
            LANE_FILL: begin
                if (end_line) begin
                    lane    = {SHA3_PAD_FINAL, 56'h0};
                    msg_end = 1'b1;
                end
            end
            default: lane = '0;
        endcase
    end

endmodule

// File: rtl/sha3_msg_padder.sv
// Turns a 64-bit message word stream into pad10*1-padded rate blocks, one lane per output handshake.
// A single registered output slot gives one cycle of latency and holds its lane while stalled.
module sha3_msg_padder
    import pkg_sha3::*;
#(
    parameter int         RATE_LINES  = SHA3_RATE_LINES,
    parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN_SHA3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_block_last,
    output logic        out_msg_last
);

    localparam int                LINE_W   = $clog2(RATE_LINES);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(RATE_LINES - 1);

    ssPad_t            state;
    logic [LINE_W-1:0] line_cnt;
    logic              out_ok;
    logic              load;
    lane_mode_t        lane_mode;
    logic [63:0]       lane;
    logic              full_tail;
    logic              msg_end;

    assign out_ok   = !out_valid || out_ready;
    assign in_ready = !rst && (state == ST_DATA) && out_ok;
    // Padding lanes are generated internally, so only data lanes wait for the upstream word.
    assign load     = out_ok && ((state != ST_DATA) || in_valid);

    always_comb begin
        unique case (state)
            ST_PAD:  lane_mode = LANE_PAD;
            ST_FILL: lane_mode = LANE_FILL;
            default: lane_mode = LANE_DATA;
        endcase
    end

    sha3_pad_lane_gen #(
        .RATE_LINES  (RATE_LINES),
        .DOMAIN_BYTE (DOMAIN_BYTE)
    ) u_lane_gen (
        .data      (in_data),
        .nbytes    (in_nbytes),
        .last      (in_last),
        .line      (line_cnt),
        .mode      (lane_mode),
        .lane      (lane),
        .full_tail (full_tail),
        .msg_end   (msg_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_DATA;
            line_cnt       <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else if (out_ok) begin
            out_valid <= load;
            if (load) begin
                out_data       <= lane;
                out_block_last <= (line_cnt == LINE_MAX);
                out_msg_last   <= msg_end;
                line_cnt       <= (line_cnt == LINE_MAX) ? '0 : line_cnt + LINE_W'(1);
                unique case (state)
                    ST_DATA: begin
                        if (in_last) begin
                            if (full_tail)    state <= ST_PAD;
                            else if (!msg_end) state <= ST_FILL;
                        end
                    end
                    ST_PAD:  state <= msg_end ? ST_DATA : ST_FILL;
                    ST_FILL: if (msg_end) state <= ST_DATA;
                    default: state <= ST_DATA;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha3_msg_padder.sv
// Self-checking bench for sha3_msg_padder: directed vector table, stall/reset sequences,
// and random messages compared against a byte-level pad10*1 reference model.
module tb_sha3_msg_padder;
    import pkg_sha3::*;

    localparam int RL         = SHA3_RATE_LINES;
    localparam int RATE_BYTES = RL * 8;

    typedef struct packed {
        logic        bl;
        logic        ml;
        logic [63:0] data;
    } lane_t;

    typedef struct {
        string       name;
        int          len;
        int          lane_idx;
        logic [63:0] exp_data;
        bit          exp_bl;
        bit          exp_ml;
        int          exp_total;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_nbytes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_block_last;
    logic        out_msg_last;

    sha3_msg_padder dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_nbytes      (in_nbytes),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_block_last (out_block_last),
        .out_msg_last   (out_msg_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    lane_t got[$];
    bit    rdy_rand = 1'b0;
    bit    rdy_val  = 1'b1;
    vec_t  vecs[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Reference pad10*1: append domain byte, set top bit of the last rate byte.
    function automatic void ref_pad(input logic [7:0] m[$], output lane_t lanes[$]);
        int          n    = m.size();
        int          plen = (n / RATE_BYTES + 1) * RATE_BYTES;
        logic [7:0]  p[];
        lane_t       l;
        p = new[plen];
        for (int i = 0; i < plen; i++) p[i] = (i < n) ? m[i] : 8'h00;
        p[n]        = p[n] | SHA3_DOMAIN_SHA3;
        p[plen - 1] = p[plen - 1] | SHA3_PAD_FINAL;
        lanes.delete();
        for (int w = 0; w < plen / 8; w++) begin
            for (int k = 0; k < 8; k++) l.data[8*k +: 8] = p[8*w + k];
            l.bl = ((w % RL) == RL - 1);
            l.ml = (w == plen / 8 - 1);
            lanes.push_back(l);
        end
    endfunction

    function automatic void make_seq(input int len, output logic [7:0] m[$]);
        m.delete();
        for (int i = 0; i < len; i++) m.push_back(8'(8'h61 + i));
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Output monitor: captures handshaken lanes and checks stalled lanes stay put.
    initial begin
        bit    prev_stall = 1'b0;
        lane_t prev_lane  = '0;
        lane_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur = '{out_block_last, out_msg_last, out_data};
                if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, prev_lane});
                if (out_valid && out_ready) got.push_back(cur);
                prev_stall = out_valid && !out_ready;
                prev_lane  = cur;
            end
        end
    end

    task automatic drive_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
        bit acc = 1'b0;
        int t   = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_nbytes = nb;
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = {$urandom, $urandom};
        in_nbytes = 4'($urandom_range(0, 15));
        if (!acc) check("in_accept_timeout", 0, 1);
    endtask

    task automatic send_msg(input logic [7:0] m[$], input bit gaps);
        int n  = m.size();
        int nw = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            int          nb;
            logic [63:0] d;
            nb = (w == nw - 1) ? n - 8 * w : 8;
            d  = {$urandom, $urandom};
            for (int k = 0; k < nb; k++) d[8*k +: 8] = m[8*w + k];
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drive_word(d, (w == nw - 1), 4'(nb));
        end
    endtask

    task automatic wait_lanes(input int n, input string name);
        int t = 0;
        while (got.size() < n && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) begin @(posedge clk); #1; end
        check({name, "_count"}, got.size(), n);
    endtask

    task automatic compare_stream(input string name, input lane_t exp[$]);
        for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i], exp[i]);
    endtask

    initial begin
        logic [7:0] m[$];
        lane_t      exp[$];
        lane_t      a;
        lane_t      held;

        vecs[0]  = '{"empty_l0",   0,   0, 64'h0000_0000_0000_0006, 1'b0, 1'b0, 17};
        vecs[1]  = '{"empty_l5",   0,   5, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 17};
        vecs[2]  = '{"empty_l16",  0,  16, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 17};
        vecs[3]  = '{"abc_l0",     3,   0, 64'h0000_0000_0663_6261, 1'b0, 1'b0, 17};
        vecs[4]  = '{"abc_l16",    3,  16, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 17};
        vecs[5]  = '{"m135_l15", 135,  15, 64'hE0DF_DEDD_DCDB_DAD9, 1'b0, 1'b0, 17};
        vecs[6]  = '{"m135_l16", 135,  16, 64'h86E7_E6E5_E4E3_E2E1, 1'b1, 1'b1, 17};
        vecs[7]  = '{"m136_l16", 136,  16, 64'hE8E7_E6E5_E4E3_E2E1, 1'b1, 1'b0, 34};
        vecs[8]  = '{"m136_l17", 136,  17, 64'h0000_0000_0000_0006, 1'b0, 1'b0, 34};
        vecs[9]  = '{"m136_l33", 136,  33, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 34};
        vecs[10] = '{"m128_l16", 128,  16, 64'h8000_0000_0000_0006, 1'b1, 1'b1, 17};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("reset_state", {out_valid, in_ready, out_block_last, out_msg_last, out_data}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < $size(vecs); i++) begin
            got.delete();
            make_seq(vecs[i].len, m);
            send_msg(m, 1'b0);
            wait_lanes(vecs[i].exp_total, vecs[i].name);
            a = (vecs[i].lane_idx < got.size()) ? got[vecs[i].lane_idx] : '1;
            check(vecs[i].name, a, {vecs[i].exp_bl, vecs[i].exp_ml, vecs[i].exp_data});
        end

        // Output stalled: lane 0 must appear and stay while upstream is held off.
        rdy_val = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        got.delete();
        drive_word({40'hDE_ADBE_EF55, 24'h63_6261}, 1'b1, 4'd3);
        check("stall_first", {out_valid, out_data}, {1'b1, 64'h0000_0000_0663_6261});
        held = '{out_block_last, out_msg_last, out_data};
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", {in_ready, out_block_last, out_msg_last, out_data}, {1'b0, held});
        end
        rdy_val = 1'b1;
        make_seq(3, m);
        ref_pad(m, exp);
        wait_lanes(exp.size(), "stall_drain");
        compare_stream("stall_drain", exp);

        // Reset in the middle of the fill lanes of an empty message.
        got.delete();
        make_seq(0, m);
        send_msg(m, 1'b0);
        for (int t = 0; t < 200 && got.size() < 5; t++) begin @(posedge clk); #1; end
        check("fill_reached", got.size() >= 5, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_fill_reset", {out_valid, in_ready}, 2'b00);
        rst = 1'b0;
        got.delete();
        make_seq(3, m);
        ref_pad(m, exp);
        send_msg(m, 1'b0);
        wait_lanes(exp.size(), "post_reset_abc");
        compare_stream("post_reset_abc", exp);

        // Random messages with random back-pressure and input gaps.
        rdy_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int len = $urandom_range(1, 500);
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            ref_pad(m, exp);
            got.delete();
            send_msg(m, 1'b1);
            wait_lanes(exp.size(), "rand_msg");
            compare_stream("rand_msg", exp);
        end
        rdy_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
